// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one outstanding req/ack bus access, store lane steering,
// load extension and exceptions. Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_lsu #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_alu_out_m,
  input  logic [31:0]       i_haz_b_m,
  input  logic [6:0]        i_opcode_m,
  input  logic [2:0]        i_f3_m,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_be,
  input  logic              i_bus_ack,
  input  logic              i_bus_err,
  input  logic [31:0]       i_bus_rdata,
  output logic [31:0]       o_load_data_m,
  output logic              o_stall_m,
  output logic [3:0]        o_exception_code_m
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [3:0] CodeNone = 4'b1111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              err_q, err_d;
  logic [31:0]       load_data_q, load_data_d;

  logic        is_load, is_store, mem_op, f3_legal, misaligned, access_ok;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'b0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Decode of the EX/MEM instruction currently presented.
  always_comb begin
    is_load  = (i_opcode_m == OpLoad);
    is_store = (i_opcode_m == OpStore);
    mem_op   = is_load | is_store;
    f3_legal = 1'b0;
    if (is_load) begin
      f3_legal = (i_f3_m == 3'b000) || (i_f3_m == 3'b001) || (i_f3_m == 3'b010) ||
                 (i_f3_m == 3'b100) || (i_f3_m == 3'b101);
    end else if (is_store) begin
      f3_legal = !i_f3_m[2] && (i_f3_m[1:0] != 2'b11);
    end
    misaligned = ((i_f3_m[1:0] == 2'b01) && i_alu_out_m[0]) ||
                 ((i_f3_m[1:0] == 2'b10) && (i_alu_out_m[1:0] != 2'b00));
    access_ok  = mem_op && f3_legal && !misaligned;

    st_be    = 4'b0000;
    st_wdata = 32'b0;
    if (is_store) begin
      case (i_f3_m[1:0])
        2'b00: begin
          st_be    = 4'b0001 << i_alu_out_m[1:0];
          st_wdata = {4{i_haz_b_m[7:0]}};
        end
        2'b01: begin
          st_be    = i_alu_out_m[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{i_haz_b_m[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = i_haz_b_m;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    err_d       = err_q;
    load_data_d = load_data_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (access_ok) begin
          state_d = StBusy;
          we_d    = is_store;
          addr_d  = {i_alu_out_m[ADDR_W-1:2], 2'b00};
          be_d    = st_be;
          wdata_d = st_wdata;
          f3_d    = i_f3_m;
          off_d   = i_alu_out_m[1:0];
          err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        if (i_bus_ack) begin
          state_d = StDone;
          err_d   = i_bus_err;
          if (!we_q) load_data_d = extract(i_bus_rdata, f3_q, off_q);
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the request and report it as an access fault.
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0;
      wdata_q     <= 32'b0;
      f3_q        <= 3'b0;
      off_q       <= 2'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign o_load_data_m = load_data_q;

  always_comb begin
    o_bus_req          = 1'b0;
    o_bus_we           = 1'b0;
    o_bus_addr         = '0;
    o_bus_wdata        = 32'b0;
    o_bus_be           = 4'b0;
    o_stall_m          = 1'b0;
    o_exception_code_m = CodeNone;
    unique case (state_q)
      StIdle: begin
        o_stall_m = access_ok;
        if (mem_op) begin
          if (!f3_legal)      o_exception_code_m = 4'd2;
          else if (misaligned) o_exception_code_m = is_load ? 4'd4 : 4'd6;
        end
      end
      StBusy: begin
        o_bus_req   = 1'b1;
        o_bus_we    = we_q;
        o_bus_addr  = addr_q;
        o_bus_wdata = wdata_q;
        o_bus_be    = be_q;
        o_stall_m   = 1'b1;
      end
      StDone: begin
        if (err_q) o_exception_code_m = we_q ? 4'd7 : 4'd5;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu; define MEM_TIMEOUT_EN to exercise the bus timeout path.
module tb_mem_lsu;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, hazb, rdata, wdata, load_data;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        req, we, ack, err, stall;
  logic [31:0] addr;
  logic [3:0]  be, code;

  int checks = 0;
  int errors = 0;

  int          req_n, stall_n;
  logic [31:0] cap_addr, cap_wdata, done_data, idle_data;
  logic [3:0]  cap_be, done_code;
  logic        cap_we, done_stall;

  mem_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_alu_out_m        (alu),
    .i_haz_b_m          (hazb),
    .i_opcode_m         (opcode),
    .i_f3_m             (f3),
    .o_bus_req          (req),
    .o_bus_we           (we),
    .o_bus_addr         (addr),
    .o_bus_wdata        (wdata),
    .o_bus_be           (be),
    .i_bus_ack          (ack),
    .i_bus_err          (err),
    .i_bus_rdata        (rdata),
    .o_load_data_m      (load_data),
    .o_stall_m          (stall),
    .o_exception_code_m (code)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: IDLE, waits+1 BUSY cycles (ack on the last), DONE, back to IDLE.
  task automatic access(input logic [6:0] op, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int waits, input logic [31:0] rd,
                        input logic er, input logic noise);
    req_n   = 0;
    stall_n = 0;
    opcode = op; f3 = fn; alu = a; hazb = b;
    #1;
    req_n   += int'(req);
    stall_n += int'(stall);
    for (int i = 0; i <= waits; i++) begin
      tick;
      if (i == waits) begin
        ack = 1'b1; err = er; rdata = rd;
      end else begin
        ack = 1'b0; err = noise; rdata = 32'h0bad_0bad;
      end
      #1;
      if (i == 0) begin
        cap_addr = addr; cap_wdata = wdata; cap_be = be; cap_we = we;
      end
      req_n   += int'(req);
      stall_n += int'(stall);
    end
    tick;
    ack = 1'b0; err = 1'b0; opcode = 7'h00;
    #1;
    done_code  = code;
    done_data  = load_data;
    done_stall = stall;
    req_n   += int'(req);
    stall_n += int'(stall);
    tick;
    idle_data = load_data;
  endtask

  initial begin
    int n;
    rst = 1'b1; alu = 0; hazb = 0; rdata = 0; opcode = 0; f3 = 0; ack = 0; err = 0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("rst_req", 32'(req), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_be", 32'(be), 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_ldata", load_data, 32'h0);
    check("rst_code", 32'(code), 32'hf);
    check("rst_stall", 32'(stall), 32'h0);

    // LW with two wait cycles
    access(LD, 3'b010, 32'h100, 32'h0, 2, 32'hdead_beef, 1'b0, 1'b0);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_be", 32'(cap_be), 32'h0);
    check("lw_we", 32'(cap_we), 32'h0);
    check("lw_req_cycles", 32'(req_n), 32'd3);
    check("lw_stall_cycles", 32'(stall_n), 32'd4);
    check("lw_data", done_data, 32'hdead_beef);
    check("lw_code", 32'(done_code), 32'hf);
    check("lw_done_stall", 32'(done_stall), 32'h0);
    check("lw_data_held", idle_data, 32'hdead_beef);

    access(LD, 3'b000, 32'h203, 32'h0, 0, 32'h80ff_ff12, 1'b0, 1'b0);
    check("lb_data", done_data, 32'hffff_ff80);
    access(LD, 3'b100, 32'h203, 32'h0, 0, 32'h80ff_ff12, 1'b0, 1'b0);
    check("lbu_data", done_data, 32'h0000_0080);
    access(LD, 3'b001, 32'h202, 32'h0, 0, 32'h80ff_ff12, 1'b0, 1'b0);
    check("lh_data", done_data, 32'hffff_80ff);
    access(LD, 3'b101, 32'h200, 32'h0, 0, 32'h80ff_ff12, 1'b0, 1'b0);
    check("lhu_data", done_data, 32'h0000_ff12);

    // Stores
    access(ST, 3'b001, 32'h302, 32'h1234_abcd, 0, 32'h0, 1'b0, 1'b0);
    check("sh_addr", cap_addr, 32'h300);
    check("sh_be", 32'(cap_be), 32'hc);
    check("sh_wdata", cap_wdata, 32'habcd_abcd);
    check("sh_we", 32'(cap_we), 32'h1);
    check("sh_stall_cycles", 32'(stall_n), 32'd2);
    check("sh_req_cycles", 32'(req_n), 32'd1);
    check("sh_code", 32'(done_code), 32'hf);
    check("sh_ldata_kept", done_data, 32'h0000_ff12);
    access(ST, 3'b000, 32'h301, 32'h0000_00cd, 0, 32'h0, 1'b0, 1'b0);
    check("sb_be", 32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'hcdcd_cdcd);
    access(ST, 3'b010, 32'h400, 32'hcafe_f00d, 0, 32'h0, 1'b1, 1'b0);
    check("sw_be", 32'(cap_be), 32'hf);
    check("sw_wdata", cap_wdata, 32'hcafe_f00d);
    check("sw_err_code", 32'(done_code), 32'h7);
    check("sw_err_stall", 32'(done_stall), 32'h0);
    check("sw_err_ldata", done_data, 32'h0000_ff12);

    // Misaligned, illegal and non-memory instructions
    opcode = LD; f3 = 3'b010; alu = 32'h101;
    #1;
    check("lw_mis_code", 32'(code), 32'h4);
    check("lw_mis_stall", 32'(stall), 32'h0);
    check("lw_mis_req", 32'(req), 32'h0);
    tick;
    check("lw_mis_req_next", 32'(req), 32'h0);
    opcode = ST; f3 = 3'b001; alu = 32'h103;
    #1;
    check("sh_mis_code", 32'(code), 32'h6);
    check("sh_mis_stall", 32'(stall), 32'h0);
    opcode = LD; f3 = 3'b011; alu = 32'h100;
    #1;
    check("ld_ill_code", 32'(code), 32'h2);
    check("ld_ill_stall", 32'(stall), 32'h0);
    opcode = ST; f3 = 3'b100;
    #1;
    check("st_ill_code", 32'(code), 32'h2);
    opcode = 7'b0110011; f3 = 3'b000;
    #1;
    check("alu_op_code", 32'(code), 32'hf);
    check("alu_op_stall", 32'(stall), 32'h0);
    tick;
    check("alu_op_req", 32'(req), 32'h0);
    opcode = 7'h00;

    // Ack while idle is ignored
    ack = 1'b1; rdata = 32'hffff_ffff;
    tick;
    ack = 1'b0;
    #1;
    check("idle_ack_ldata", load_data, 32'h0000_ff12);
    check("idle_ack_req", 32'(req), 32'h0);
    check("idle_ack_code", 32'(code), 32'hf);

    // err without ack during waits is ignored
    access(LD, 3'b010, 32'h104, 32'h0, 1, 32'h1122_3344, 1'b0, 1'b1);
    check("noise_code", 32'(done_code), 32'hf);
    check("noise_data", done_data, 32'h1122_3344);
    check("noise_req_cycles", 32'(req_n), 32'd2);

    // Reset in the middle of BUSY
    opcode = LD; f3 = 3'b010; alu = 32'h500;
    tick;
    check("mid_busy_req", 32'(req), 32'h1);
    rst = 1'b1; opcode = 7'h00;
    tick;
    check("rst_busy_req", 32'(req), 32'h0);
    check("rst_busy_stall", 32'(stall), 32'h0);
    check("rst_busy_ldata", load_data, 32'h0);
    rst = 1'b0;
    access(LD, 3'b010, 32'h500, 32'h0, 0, 32'h55aa_55aa, 1'b0, 1'b0);
    check("post_rst_req_cycles", 32'(req_n), 32'd1);
    check("post_rst_data", done_data, 32'h55aa_55aa);

`ifdef MEM_TIMEOUT_EN
    opcode = LD; f3 = 3'b010; alu = 32'h600;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      n += int'(req);
    end
    check("to_req_cycles", 32'(n), 32'd4);
    tick;
    check("to_done_req", 32'(req), 32'h0);
    check("to_done_code", 32'(code), 32'h5);
    check("to_done_stall", 32'(stall), 32'h0);
    opcode = 7'h00;
    tick;
    ack = 1'b1; rdata = 32'h1234_5678;
    #1;
    check("to_late_ack_req", 32'(req), 32'h0);
    check("to_late_ack_code", 32'(code), 32'hf);
    tick;
    ack = 1'b0;
    #1;
    check("to_late_ack_ldata", load_data, 32'h55aa_55aa);
    check("to_late_ack_req2", 32'(req), 32'h0);
`else
    opcode = LD; f3 = 3'b010; alu = 32'h600;
    tick;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      n += int'(req);
      tick;
    end
    check("noto_req_cycles", 32'(n), 32'd100);
    check("noto_stall", 32'(stall), 32'h1);
    ack = 1'b1; rdata = 32'h600d_f00d;
    tick;
    ack = 1'b0; opcode = 7'h00;
    #1;
    check("noto_data", load_data, 32'h600d_f00d);
    check("noto_code", 32'(code), 32'hf);
    check("noto_done_stall", 32'(stall), 32'h0);
    tick;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit: the consumer of the EX/MEM pipeline register outputs.
- Decodes the registered opcode and f3, then drives a single-outstanding req/ack data-bus transaction:
  - store byte-lane steering;
  - load extraction with sign/zero extension;
  - misalignment and bus-error exceptions.
- Stalls the pipeline (o_stall_m feeds the upstream clock enables) until the access completes.

Parameters:
- ADDR_W, 32, bus address width; the low 2 bits are always driven 0.
- TIMEOUT_CYCLES, 16, cycles in BUSY before a timeout fault. Used only with MEM_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_alu_out_m  in  32  effective address.
- i_haz_b_m  in  32  store data (forwarded rs2).
- i_opcode_m  in  7  0000011 = load, 0100011 = store, anything else = no access.
- i_f3_m  in  3  access width/sign.
- o_bus_req  out  1  request valid.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}.
- o_bus_wdata  out  32  lane-replicated store data.
- o_bus_be  out  4  byte enables.
- i_bus_ack  in  1  transaction complete.
- i_bus_err  in  1  access fault, qualified by i_bus_ack.
- i_bus_rdata  in  32  read word, valid with ack.
- o_load_data_m  out  32  extended load result, valid in DONE.
- o_stall_m  out  1  hold IF/ID/EX and EX/MEM.
- o_exception_code_m  out  4  RISC-V mcause code; 4'b1111 = none.

Behaviour:
Synchronous active-high reset; all outputs as follows in IDLE:
- Reset state IDLE; o_bus_req=0, o_bus_we=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0, o_load_data_m=0, o_exception_code_m=4'b1111.
- o_stall_m = 1 in IDLE only when a valid aligned access is present; otherwise 0.

Legal f3 encodings:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other f3 with a load/store opcode: combinational code 4'd2 (illegal instruction), no bus access, no stall.

Misalignment:
- Misaligned when halfword addr[0]=1, or word addr[1:0]!=0.
- Output combinational code 4'd4 (load) or 4'd6 (store) in IDLE; no request, no stall.

FSM states:
- IDLE:
  - Aligned access: latch we, addr, be, wdata, f3 and addr[1:0]; go to BUSY.
  - o_stall_m=1 combinationally in this cycle.
- BUSY:
  - o_bus_req=1; all bus outputs held stable until ack.
  - o_stall_m=1.
  - On i_bus_ack: capture rdata and err; go to DONE.
  - Without ack: remain in BUSY.
- DONE (exactly one cycle):
  - o_stall_m=0 so the pipeline advances.
  - o_load_data_m valid.
  - o_exception_code_m = 5 (load fault) or 7 (store fault) if err was captured, else 4'b1111.
  - Return to IDLE.

Timing:
- Zero-wait ack gives 3 MEM cycles: IDLE, BUSY, DONE.
- Each extra wait cycle adds one cycle.

Store lanes:
- SB: be = 4'b0001 << addr[1:0]; wdata = {4{b[7:0]}}.
- SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{b[15:0]}}.
- SW: be = 4'b1111; wdata = b.
- o_bus_be=0 on loads; the bus returns the full word.

Load extraction (from the captured word and offset):
- LB/LBU: byte at offset, sign- or zero-extended to 32 bits.
- LH/LHU: halfword selected by offset[1], sign- or zero-extended.
- LW: the whole word.
- o_load_data_m holds its value outside DONE.

Boundary conditions:
- A store with a bus error produces no load data; o_load_data_m keeps its previous value.
- i_bus_ack outside BUSY is ignored.
- i_bus_err without ack is ignored.
- Reset mid-BUSY: req drops the next cycle and state returns to IDLE; the bus master must tolerate an abandoned request.
- Non-memory opcodes: IDLE, no stall, code 4'b1111.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES, drop req and go to DONE with code 5 (load) or 7 (store).
  - A late ack in the following IDLE is ignored.
- Undefined: no counter; BUSY waits indefinitely for ack.

Test Plan:
- LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> addr 0x100, be=0, req held 3 cycles, stall 4 cycles, DONE load_data=0xDEADBEEF, code 4'b1111.
- LB addr 0x203, rdata 0x80FF_FF12 -> load_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH addr 0x302, haz_b 0x1234ABCD, immediate ack -> addr 0x300, be=4'b1100, wdata 0xABCDABCD, we=1, stall exactly 2 cycles.
- LW addr 0x101 -> code 4 same cycle, no req, stall 0; SH addr 0x103 -> code 6.
- SW addr 0x400, ack with err=1 -> DONE code 7, stall released. Assert i_rst mid-BUSY on a new LW -> req=0 and state IDLE one cycle later.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LW with no ack -> req drops after 4 BUSY cycles, code 5; late ack ignored. Without the macro, req held for 100 cycles.
